// File: rtl/period_meter.sv
// period_meter: measures one period of a slow asynchronous signal in clk cycles.
//
// A single measurement is requested with start. After the first synchronized rising
// edge of sig_in the block counts clk cycles up to the next rising edge (period) and
// how many of those cycles sig_in was high (high_time). If the measurement is not
// complete within TIMEOUT cycles of start, it ends with timeout set and zero results.
//
// Parameters
//   WIDTH      counter and result width in bits
//   TIMEOUT    maximum measurement length in clk cycles (4 .. 2^WIDTH-1)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   sig_in     asynchronous signal under measurement
//   start      single-cycle request to begin a measurement (honoured in idle only)
//   abort      cancels a measurement in progress, no done pulse, results untouched
//   busy       high while a measurement is in progress
//   done       one-cycle pulse on completion or timeout
//   period     clk cycles between two consecutive sig_in rising edges
//   high_time  clk cycles sig_in was high within that period
//   timeout    set when the last measurement expired without completing
module period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             timeout
);

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StMeas
  } state_e;

  // Last value tcnt takes before the measurement expires.
  localparam logic [WIDTH-1:0] TcntLast = WIDTH'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CntOne   = WIDTH'(1);

  state_e           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcnt_q, hcnt_d;
  logic [WIDTH-1:0] tcnt_q, tcnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;

  logic             rise;
  logic             expire;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (v == '1) ? v : v + CntOne;
  endfunction

  // Two-flop synchronizer plus one history flop for edge detection.
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign rise   = s2_q & ~s3_q;
  assign expire = (tcnt_q == TcntLast);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hcnt_d      = hcnt_q;
    tcnt_d      = tcnt_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StArm;
          tcnt_d  = '0;
        end
      end

      StArm: begin
        tcnt_d = tcnt_q + CntOne;
        if (abort) begin
          state_d = StIdle;
        end else if (expire) begin
          // A rise seen in the very last armed cycle only starts a period, so it
          // cannot complete one; the measurement expires.
          period_d    = '0;
          high_time_d = '0;
          timeout_d   = 1'b1;
          done_d      = 1'b1;
          state_d     = StIdle;
        end else if (rise) begin
          // The rise cycle itself is the first cycle of the period and is high.
          cnt_d   = CntOne;
          hcnt_d  = CntOne;
          state_d = StMeas;
        end
      end

      StMeas: begin
        tcnt_d = tcnt_q + CntOne;
        if (abort) begin
          state_d = StIdle;
        end else if (rise) begin
          // A completing rise wins over a simultaneous expiry.
          period_d    = cnt_q;
          high_time_d = hcnt_q;
          timeout_d   = 1'b0;
          done_d      = 1'b1;
          state_d     = StIdle;
        end else if (expire) begin
          period_d    = '0;
          high_time_d = '0;
          timeout_d   = 1'b1;
          done_d      = 1'b1;
          state_d     = StIdle;
        end else begin
          cnt_d = sat_inc(cnt_q);
          if (s2_q) begin
            hcnt_d = sat_inc(hcnt_q);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      s3_q        <= 1'b0;
      cnt_q       <= '0;
      hcnt_q      <= '0;
      tcnt_q      <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      cnt_q       <= cnt_d;
      hcnt_q      <= hcnt_d;
      tcnt_q      <= tcnt_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign period    = period_q;
  assign high_time = high_time_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter (WIDTH=16, TIMEOUT=100).
// Expected results come from a table of hand-derived vectors and from a reference
// model that works on the recorded sig_in waveform: a rising sample is seen by the
// core two edges later, the period is the distance between two such edges after
// start, and high_time is the number of high samples within that period.
module tb_period_meter;

  localparam int TMO  = 100;
  localparam int MAXL = 128;

  logic        clk;
  logic        rst;
  logic        sig_in;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        timeout;

  period_meter #(
    .WIDTH  (16),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .period   (period),
    .high_time(high_time),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Every sig_in value presented at each clk edge, indexed by edge number.
  bit hist[$];
  int hist_base = 0;      // samples before this index count as 0 (reset clears history)
  bit fut[0:MAXL-1];      // waveform of the run about to be driven

  int prev_p = 0;
  int prev_h = 0;
  bit prev_t = 1'b0;

  typedef struct {
    int p;
    int h;
    int ph;
    int sdel;
    int xp;
    int xh;
    bit xt;
    int lat;   // cycles from start to done, -1 = take from model
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wv(input int j, input int p, input int h, input int ph);
    if (p == 0) return 1'b0;
    return ((j + ph) % p) < h;
  endfunction

  function automatic bit samp(input int k);
    if (k < hist_base || k < 0) return 1'b0;
    if (k < hist.size()) return hist[k];
    return fut[k - hist.size()];
  endfunction

  task automatic tick(input bit s, input bit st, input bit ab);
    sig_in = s;
    start  = st;
    abort  = ab;
    hist.push_back(s);
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Reference model: start sampled at edge s_abs; returns the edge at which done rises
  // and the results it carries.
  task automatic predict(input int s_abs, output int d_abs, output int xp, output int xh,
                         output bit xt);
    int e1;
    bit found;
    e1    = -1;
    found = 1'b0;
    d_abs = s_abs + TMO;
    xp    = 0;
    xh    = 0;
    xt    = 1'b1;
    for (int e = s_abs + 1; e <= s_abs + TMO; e++) begin
      if (!found) begin
        bit r;
        r = samp(e - 2) && !samp(e - 3);
        if (e1 < 0) begin
          if (r && e != s_abs + TMO) e1 = e;
        end else if (r) begin
          found = 1'b1;
          d_abs = e;
          xp    = e - e1;
          xt    = 1'b0;
          for (int k = e1 - 2; k <= e - 3; k++) xh += int'(samp(k));
        end
      end
    end
  endtask

  task automatic run_meas(input int p, input int h, input int ph, input int sdel,
                          input bit use_exp, input int xp, input int xh, input bit xt,
                          input int lat, input string name);
    int base, d_abs, mp, mh, dl, ep, eh;
    bit mt, et;
    base = hist.size();
    for (int j = 0; j < MAXL; j++) fut[j] = wv(j, p, h, ph);
    predict(base + sdel, d_abs, mp, mh, mt);
    dl = (lat >= 0) ? sdel + lat : d_abs - base;
    ep = use_exp ? xp : mp;
    eh = use_exp ? xh : mh;
    et = use_exp ? xt : mt;
    for (int j = 0; j < dl + 2; j++) begin
      tick(fut[j], j == sdel, 1'b0);
      chk({name, ".busy"}, 32'(busy), 32'(j >= sdel && j < dl));
      chk({name, ".done"}, 32'(done), 32'(j == dl));
      if (j == dl) begin
        chk({name, ".period"}, 32'(period), ep);
        chk({name, ".high_time"}, 32'(high_time), eh);
        chk({name, ".timeout"}, 32'(timeout), 32'(et));
        prev_p = ep;
        prev_h = eh;
        prev_t = et;
      end else begin
        chk({name, ".period_hold"}, 32'(period), prev_p);
        chk({name, ".high_hold"}, 32'(high_time), prev_h);
        chk({name, ".timeout_hold"}, 32'(timeout), 32'(prev_t));
      end
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".busy"}, 32'(busy), 0);
    chk({name, ".done"}, 32'(done), 0);
    chk({name, ".period"}, 32'(period), 0);
    chk({name, ".high_time"}, 32'(high_time), 0);
    chk({name, ".timeout"}, 32'(timeout), 0);
  endtask

  initial begin
    // p, h, phase, start delay, period, high_time, timeout, latency
    tbl[0] = '{10, 5, 0, 3, 10, 5, 1'b0, -1};
    tbl[1] = '{7, 2, 3, 2, 7, 2, 1'b0, -1};
    tbl[2] = '{7, 2, 5, 4, 7, 2, 1'b0, -1};
    tbl[3] = '{12, 6, 0, 2, 12, 6, 1'b0, -1};
    tbl[4] = '{0, 0, 0, 4, 0, 0, 1'b1, TMO};      // sig_in held low
    tbl[5] = '{1, 1, 0, 5, 0, 0, 1'b1, TMO};      // sig_in held high
    tbl[6] = '{60, 20, 20, 2, 60, 20, 1'b0, TMO}; // second rise on the expiry cycle
    tbl[7] = '{60, 20, 20, 1, 0, 0, 1'b1, TMO};   // second rise one cycle too late

    rst    = 1'b1;
    sig_in = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    chk_all_zero("reset");
    rst       = 1'b0;
    hist_base = hist.size();
    for (int j = 0; j < 4; j++) begin
      tick(1'b0, 1'b0, 1'b0);
      chk("idle.busy", 32'(busy), 0);
    end

    for (int i = 0; i < 8; i++) begin
      run_meas(tbl[i].p, tbl[i].h, tbl[i].ph, tbl[i].sdel, 1'b1, tbl[i].xp, tbl[i].xh,
               tbl[i].xt, tbl[i].lat, $sformatf("row%0d", i));
    end

    // Abort three cycles after the first rise event (rise sample at j=5, seen at edge
    // 7); the concurrent start is ignored. Later abort+start in idle does nothing.
    for (int j = 0; j < 34; j++) begin
      tick(wv(j, 10, 5, 5), (j == 2) || (j == 10) || (j == 31), (j == 10) || (j == 31));
      chk("abort.busy", 32'(busy), 32'(j >= 2 && j < 10));
      chk("abort.done", 32'(done), 0);
      chk("abort.period", 32'(period), prev_p);
      chk("abort.high_time", 32'(high_time), prev_h);
      chk("abort.timeout", 32'(timeout), 32'(prev_t));
    end

    for (int i = 0; i < 10; i++) begin
      int p, h, ph, sd;
      p  = int'($urandom_range(45, 2));
      h  = int'($urandom_range(p - 1, 1));
      ph = int'($urandom_range(p - 1, 0));
      sd = int'($urandom_range(5, 0));
      run_meas(p, h, ph, sd, 1'b0, 0, 0, 1'b0, -1, $sformatf("rand%0d", i));
    end

    // Reset in the middle of a measurement (rise sample at j=6, in MEAS from edge 8).
    for (int j = 0; j < 11; j++) begin
      tick(wv(j, 12, 6, 6), j == 1, 1'b0);
    end
    chk("pre_rst.busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    tick(1'b1, 1'b1, 1'b0);
    chk_all_zero("rst_hold");
    tick(1'b0, 1'b1, 1'b0);
    chk_all_zero("rst_hold");
    rst       = 1'b0;
    hist_base = hist.size();
    prev_p    = 0;
    prev_h    = 0;
    prev_t    = 1'b0;
    run_meas(12, 6, 0, 2, 1'b1, 12, 6, 1'b0, -1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors",
             checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, which sets the counter and result width in bits.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000000, which is the maximum measurement length in clk cycles; legal range is 4 .. 2^WIDTH-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port sig_in, input, 1 bit: the asynchronous slow signal under measurement, typically a divided-clock tap.
REQ-006 The block SHALL have port start, input, 1 bit: a single-cycle request to begin one measurement.
REQ-007 The block SHALL have port abort, input, 1 bit: cancels a measurement in progress.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a measurement is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a measurement completes or times out.
REQ-010 The block SHALL have port period, output, WIDTH bits: clk cycles between two consecutive sig_in rising edges.
REQ-011 The block SHALL have port high_time, output, WIDTH bits: clk cycles sig_in was high within that period.
REQ-012 The block SHALL have port timeout, output, 1 bit: set when the last measurement expired without completing.

Function
REQ-013 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
REQ-014 A rise event SHALL be s2=1 and s3=0, detected 2-3 clk cycles after the sig_in transition.
REQ-015 The FSM SHALL have exactly three states: IDLE, ARM and MEAS. busy SHALL be 1 in ARM and MEAS, and 0 in IDLE.
REQ-016 IDLE to ARM SHALL occur on start=1 and abort=0; the same transition SHALL clear the timeout counter tcnt to 0.
REQ-017 start SHALL be ignored outside IDLE.
REQ-018 ARM to MEAS SHALL occur on a rise event; the same transition SHALL load cnt=1 and hcnt=1.
REQ-019 In MEAS, each cycle without a rise event SHALL increment cnt by 1, and SHALL increment hcnt by 1 when s2=1.
REQ-020 On a rise event in MEAS, the block SHALL load period<=cnt and high_time<=hcnt, clear timeout, pulse done for one cycle, and go to IDLE.
REQ-021 The result SHALL be visible in the cycle after the rise event, coincident with done.
REQ-022 tcnt SHALL increment every cycle in ARM and MEAS.
REQ-023 When tcnt==TIMEOUT-1 and no completing rise occurs that cycle, the block SHALL load period<=0 and high_time<=0, set timeout<=1, pulse done, and go to IDLE.
REQ-024 A rise event in MEAS and timeout expiry in the same cycle SHALL resolve in favour of the rise event (valid result).
REQ-025 abort=1 in ARM or MEAS SHALL return the FSM to IDLE next cycle with no done pulse and period, high_time and timeout unchanged.
REQ-026 abort SHALL take priority over start, rise and timeout; abort in IDLE SHALL have no effect.
REQ-027 cnt and hcnt SHALL saturate at all-ones and never wrap.
REQ-028 period, high_time and timeout SHALL hold their values until the next completion or timeout.
REQ-029 A constant-high sig_in SHALL produce no rise event, so the measurement ends by timeout.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, s1=s2=s3=0, cnt=hcnt=tcnt=0, busy=0, done=0, period=0, high_time=0 and timeout=0.
REQ-031 rst asserted during ARM or MEAS SHALL discard the measurement with no done pulse.
REQ-032 After rst is released, the first rise event SHALL still require s3=0 to s2=1, and start SHALL be needed again.

Verification
REQ-033 sig_in with period 10 clk and 5 high, start pulse: bench SHALL see busy=1, then done for one cycle with period=10, high_time=5 and timeout=0.
REQ-034 sig_in with period 7 clk and 2 high (clk/7-style tap): bench SHALL see period=7 and high_time=2; repeated starts SHALL give the same result.
REQ-035 TIMEOUT=100, sig_in held 0, start at cycle N: bench SHALL see done and timeout=1 at cycle N+100, with period=0 and high_time=0.
REQ-036 abort asserted 3 cycles after the first rise event: bench SHALL see busy drop next cycle, no done, and previous period retained; start in the same cycle as abort SHALL be ignored.
REQ-037 rst pulsed mid-MEAS, then start with sig_in period 12: bench SHALL see all outputs 0 during reset, then period=12 and no spurious done.
REQ-038 TIMEOUT chosen so expiry coincides with the second rise event: bench SHALL see a valid period with timeout=0.
